// File: rtl/mdu_iter_if.sv
// ============================================================================
// Module   : mdu_iter_if
// Brief    : Request/response bundle between the EX stage and the
//            iterative multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [1:0]             op;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   flush;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;

  modport master (
    output start, op, A, B, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit producing {HI,LO}, one
//            result bit per cycle over WIDTH iterations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mdu_iter_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   diff_lo;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] mul_fix;

  // acc holds {HI,LO}: multiply shifts right with the multiplier in LO,
  // divide shifts left with the dividend in LO and the remainder in HI.
  always_comb begin
    a_mag    = sa_q ? -a_q : a_q;
    b_mag    = sb_q ? -b_q : b_q;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, b_q});
    diff_lo  = rem_sh[WIDTH-1:0] - b_q;
    div_step = {(div_ge ? diff_lo : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    mul_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    // A zero divisor leaves remainder=|A| so HI restores A after the sign fix
    quo_fix  = (b_q == '0) ? '1 :
               ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (bus.flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            state_d = S_PREP;
            div_d   = bus.op[1];
            a_d     = bus.A;
            b_d     = bus.B;
            sa_d    = ~bus.op[0] & bus.A[WIDTH-1];
            sb_d    = ~bus.op[0] & bus.B[WIDTH-1];
          end
        end
        S_PREP: begin
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = div_q ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          state_d = S_ITER;
        end
        S_ITER: begin
          acc_d = div_q ? div_step : mul_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = div_q ? {rem_fix, quo_fix} : mul_fix;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_PREP) || (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed self-checking bench for mdu_iter with an arithmetic
//            reference model compared every cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_iter_if #(.WIDTH(WIDTH)) bus ();

  mdu_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic straight from the MIPS definitions.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = 0; sy = 0; q = 0; r = 0;
    case (o)
      2'b00: begin
        sx = longint'($signed(a));
        sy = longint'($signed(b));
        p  = 64'(sx * sy);
      end
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          sx = longint'($signed(a));
          sy = longint'($signed(b));
          q  = sx / sy;
          r  = sx % sy;
          p  = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return p;
  endfunction

  // Transaction-level model: a latency countdown plus the reference result.
  logic        m_busy, m_done;
  logic [63:0] m_res, m_pend;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (bus.flush) begin
        m_busy <= 1'b0;
      end else if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (bus.start && !bus.flush) begin
      m_busy <= 1'b1;
      m_cnt  <= WIDTH + 2;
      m_pend <= ref_op(bus.op, bus.A, bus.B);
    end
  end

  always @(negedge clk) begin
    chk("model_busy", 64'(bus.busy), 64'(m_busy));
    chk("model_done", 64'(bus.done), 64'(m_done));
    chk("model_result", bus.result, m_res);
    if (bus.busy && bus.done) chk("busy_and_done", 64'd1, 64'd0);
  end

  // Issue one op and wait for done; optionally poke start mid-flight and in DONE.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int inj_at);
    int n, busy_n;
    bit got;
    n = 0; busy_n = 0; got = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    repeat (100) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      if (inj_at != 0 && n == inj_at) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'd9; bus.B = 32'd9;
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(n), 64'd35);
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd34);
    chk({nm, "_result"}, bus.result, exp);
    if (inj_at != 0) begin
      bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'd9; bus.B = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      chk({nm, "_start_in_done"}, 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic expect_no_done(input string nm, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu",      2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 0);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF, 0);
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);

    // Abort an in-flight divide: no done and the previous result stays.
    issue(2'b11, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    expect_no_done("flush_no_done", 40);
    chk("flush_result_kept", bus.result, 64'h0000_0000_8000_0000);

    run_op("start_while_busy", 2'b01, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 5);
    expect_no_done("busy_start_ignored", 40);

    // start and flush together in IDLE: not accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.A = 32'd2; bus.B = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("start_flush_busy", 64'(bus.busy), 64'd0);
    expect_no_done("start_flush_no_done", 40);

    // Reset in the middle of iteration.
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_result", bus.result, 64'd0);
    run_op("after_rst", 2'b01, 32'd3, 32'd5, 64'd15, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
